// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus: imem request/response, decode handshake, redirect
// Purpose: bundles every handshake/bus signal of the fetch stage.
// Ports (signals):
//   imem_req_valid/ready/addr   request channel toward instruction memory
//   imem_rsp_valid/data         in-order response channel from instruction memory
//   d_valid/ready/pc/instr      {pc, instr} channel toward decode
//   redirect_valid/pc           flush and restart request from execute
// Modports: master = fetch stage side, slave = environment side.
interface fetch_stage_if #(
  parameter int XLEN = 32
) ();
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            d_valid;
  logic            d_ready;
  logic [XLEN-1:0] d_pc;
  logic [31:0]     d_instr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, d_valid, d_pc, d_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, d_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, d_valid, d_pc, d_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, d_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - sequential instruction fetch with in-order buffer and redirect flush
// Purpose: issues word-aligned sequential fetches, buffers up to FIFO_DEPTH in-flight or
//   fetched instructions, hands {pc, instr} to decode, and on redirect restarts at a new PC
//   while dropping responses that belong to the flushed requests.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   fetch_stage_if.master (imem request/response, decode handshake, redirect)
module fetch_stage #(
  parameter int              XLEN       = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  // Stale responses can pile up over back-to-back redirects with a slow memory.
  localparam int DW = 16;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   alloc_q, alloc_d;
  logic [PW-1:0]   fill_q, fill_d;
  logic [PW-1:0]   head_q, head_d;
  logic [CW-1:0]   used_q, used_d;   // allocated, not yet popped
  logic [CW-1:0]   pend_q, pend_d;   // allocated, not yet filled
  logic [DW-1:0]   discard_q, discard_d;
  logic [XLEN-1:0] pc_buf_q [FIFO_DEPTH];
  logic [XLEN-1:0] pc_buf_d [FIFO_DEPTH];
  logic [31:0]     instr_buf_q [FIFO_DEPTH];
  logic [31:0]     instr_buf_d [FIFO_DEPTH];

  logic full;
  logic req_fire;
  logic rsp_drop;
  logic rsp_fill;
  logic pop;

  assign full               = (used_q == CW'(FIFO_DEPTH));
  assign bus.imem_req_valid = !rst && !full && !bus.redirect_valid;
  assign bus.imem_req_addr  = pc_q;
  // Entries fill in allocation order, so the head is filled whenever any entry is filled.
  assign bus.d_valid        = (used_q != pend_q) && !bus.redirect_valid;
  assign bus.d_pc           = pc_buf_q[head_q];
  assign bus.d_instr        = instr_buf_q[head_q];

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_drop = bus.imem_rsp_valid && (discard_q != '0);
  // A response with nothing waiting for it is a protocol violation and is ignored.
  assign rsp_fill = bus.imem_rsp_valid && (discard_q == '0) && (pend_q != '0);
  assign pop      = bus.d_valid && bus.d_ready;

  always_comb begin
    pc_d        = pc_q;
    alloc_d     = alloc_q;
    fill_d      = fill_q;
    head_d      = head_q;
    used_d      = used_q;
    pend_d      = pend_q;
    discard_d   = discard_q;
    pc_buf_d    = pc_buf_q;
    instr_buf_d = instr_buf_q;

    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc & ~XLEN'(3);
      alloc_d = '0;
      fill_d  = '0;
      head_d  = '0;
      used_d  = '0;
      pend_d  = '0;
      // Every unfilled entry still has a response coming; this cycle's response is consumed now.
      discard_d = discard_q + DW'(pend_q) - DW'(rsp_drop || rsp_fill);
    end else begin
      if (req_fire) begin
        pc_buf_d[alloc_q] = pc_q;
        alloc_d           = alloc_q + PW'(1);
        pc_d              = pc_q + XLEN'(4);
      end
      if (rsp_drop) begin
        discard_d = discard_q - DW'(1);
      end
      if (rsp_fill) begin
        instr_buf_d[fill_q] = bus.imem_rsp_data;
        fill_d              = fill_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      used_d = used_q + CW'(req_fire) - CW'(pop);
      pend_d = pend_q + CW'(req_fire) - CW'(rsp_fill);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      alloc_q   <= '0;
      fill_q    <= '0;
      head_q    <= '0;
      used_q    <= '0;
      pend_q    <= '0;
      discard_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_buf_q[i]    <= '0;
        instr_buf_q[i] <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      alloc_q     <= alloc_d;
      fill_q      <= fill_d;
      head_q      <= head_d;
      used_q      <= used_d;
      pend_q      <= pend_d;
      discard_q   <= discard_d;
      pc_buf_q    <= pc_buf_d;
      instr_buf_q <= instr_buf_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  fetch_stage_if #(.XLEN(32)) bus ();

  fetch_stage #(.XLEN(32), .FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } mrsp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  mrsp_t       mq[$];     // memory: accepted requests awaiting their response
  exp_t        exp_q[$];  // scoreboard: instructions decode must still receive, in order
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc, last_due;
  int          p_rdy, p_drdy, lat_min, lat_max;
  logic [31:0] model_pc;
  int          fires, pops, first_pop_cyc;
  logic [31:0] last_fire_addr, first_pop_pc;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic drive_idle();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.d_ready        = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    model_pc = 32'h0;
    last_due = 0;
  endtask

  task automatic clear_stats();
    fires = 0;
    pops  = 0;
    first_pop_cyc  = -1;
    first_pop_pc   = 32'hx;
    last_fire_addr = 32'hx;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    model_reset();
    #1;
    check("rst_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
    check("rst_d_valid", {31'h0, bus.d_valid}, 32'h0);
    check("rst_d_pc", bus.d_pc, 32'h0);
    check("rst_d_instr", bus.d_instr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    clear_stats();
  endtask

  // One clock cycle: drive inputs at the falling edge, check issue-side behaviour, and advance
  // the reference model for whatever handshakes complete at the next rising edge.
  task automatic step(input bit redir = 1'b0, input logic [31:0] rpc = 32'h0);
    bit    rsp_now;
    int    due;
    logic  exp_rv;
    @(negedge clk);
    cyc++;
    bus.imem_req_ready = (int'($urandom_range(99)) < p_rdy);
    bus.d_ready        = (int'($urandom_range(99)) < p_drdy);
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    rsp_now = (mq.size() > 0) && (mq[0].due <= cyc);
    bus.imem_rsp_valid = rsp_now;
    bus.imem_rsp_data  = rsp_now ? mq[0].data : $urandom;
    #2;
    exp_rv = (exp_q.size() < 4) && !redir;
    check("req_valid", {31'h0, bus.imem_req_valid}, {31'h0, exp_rv});
    if (redir) check("d_valid_in_redirect", {31'h0, bus.d_valid}, 32'h0);
    if (bus.d_valid && bus.d_ready) begin
      if (pops == 0) begin
        first_pop_pc  = bus.d_pc;
        first_pop_cyc = cyc;
      end
      pops++;
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      check("req_addr", bus.imem_req_addr, model_pc);
      last_fire_addr = bus.imem_req_addr;
      fires++;
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{data: imem_word(model_pc), due: due});
      exp_q.push_back('{pc: model_pc, instr: imem_word(model_pc)});
      model_pc = model_pc + 32'd4;
    end
    if (rsp_now) void'(mq.pop_front());
    if (redir) begin
      exp_q.delete();
      model_pc = {rpc[31:2], 2'b00};
    end
  endtask

  task automatic drain();
    p_rdy  = 0;
    p_drdy = 100;
    for (int i = 0; i < 100 && (mq.size() > 0 || exp_q.size() > 0); i++) step();
    check("drain_left", exp_q.size(), 32'h0);
    step();
    check("drain_d_valid", {31'h0, bus.d_valid}, 32'h0);
  endtask

  // Monitor: every accepted decode transfer must match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (!rst && bus.d_valid && bus.d_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: d_pc %h d_instr %h with nothing expected", bus.d_pc, bus.d_instr);
      end else begin
        e = exp_q.pop_front();
        check("d_pc", bus.d_pc, e.pc);
        check("d_instr", bus.d_instr, e.instr);
      end
    end
  end

  initial begin
    drive_idle();
    model_reset();
    clear_stats();
    cyc = 0;
    do_reset();

    // Streaming with 1-cycle memory and an always-ready decode.
    p_rdy = 100; p_drdy = 100; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20; i++) step();
    check("stream_first_pop_cycle", first_pop_cyc, 32'd3);
    check("stream_first_pc", first_pop_pc, 32'h0);
    check("stream_pops", pops, 32'd18);
    drain();

    // Decode stalled: the buffer fills after exactly four requests.
    do_reset();
    p_rdy = 100; p_drdy = 0; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 10; i++) step();
    check("stall_fires", fires, 32'd4);
    p_drdy = 100;
    for (int i = 0; i < 10; i++) step();
    check("stall_resume", {31'h0, fires > 4}, 32'h1);
    check("stall_first_pc", first_pop_pc, 32'h0);
    drain();

    // Redirect with three requests in flight on a slow memory.
    do_reset();
    p_rdy = 100; p_drdy = 100; lat_min = 5; lat_max = 5;
    for (int i = 0; i < 3; i++) step();
    step(1'b1, 32'h100);
    clear_stats();
    step();
    check("redir_req_addr", last_fire_addr, 32'h100);
    for (int i = 0; i < 15; i++) step();
    check("redir_first_pc", first_pop_pc, 32'h100);
    drain();

    // PC wrap and low-bit masking of the redirect target.
    p_rdy = 100; p_drdy = 100; lat_min = 1; lat_max = 1;
    step(1'b1, 32'hFFFF_FFFC);
    step();
    check("wrap_addr_top", last_fire_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr_zero", last_fire_addr, 32'h0);
    step(1'b1, 32'h103);
    step();
    check("redir_mask_addr", last_fire_addr, 32'h100);
    drain();

    // Redirect landing on a cycle with a response and a ready decode.
    p_rdy = 100; p_drdy = 100; lat_min = 2; lat_max = 2;
    for (int i = 0; i < 6; i++) step();
    step(1'b1, 32'h200);
    clear_stats();
    for (int i = 0; i < 10; i++) step();
    check("coincident_first_pc", first_pop_pc, 32'h200);
    drain();

    // Randomised traffic with random redirects.
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      p_rdy  = 50;
      p_drdy = 60;
      if ($urandom_range(99) < 4) step(1'b1, $urandom);
      else step();
    end
    drain();

    // Reset asserted in the middle of a burst.
    p_rdy = 100; p_drdy = 100; lat_min = 3; lat_max = 3;
    for (int i = 0; i < 6; i++) step();
    #3;
    rst = 1'b1;
    drive_idle();
    model_reset();
    #1;
    check("async_rst_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
    check("async_rst_d_valid", {31'h0, bus.d_valid}, 32'h0);
    check("async_rst_d_pc", bus.d_pc, 32'h0);
    check("async_rst_d_instr", bus.d_instr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    clear_stats();
    p_rdy = 100; p_drdy = 100; lat_min = 1; lat_max = 2;
    for (int i = 0; i < 10; i++) step();
    check("post_rst_first_pc", first_pop_pc, 32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
